spike_accumulator_array: RTL and testbench
==========================================

# spike_accumulator_array

Parametrised integrate-and-fire activation stage with `NUM_CH` channels. Each channel integrates a signed input current into a membrane potential register and fires when the potential reaches its own threshold. Each channel counts its spikes over a programmable window of steps. At the end of a window, all counts are snapshotted into an output buffer presented with a valid/ready handshake. The block sits between the PE array's accumulated partial sums and the next layer's spike encoder. It replaces the single-step activation unit with one that has a working window timer, per-channel state, two reset modes and output back-pressure.

## Interface
- `NUM_CH`, 4, number of neuron channels
- `DATA_WIDTH`, 16, width of current, potential and threshold (signed two's complement)
- `TIMER_WIDTH`, 5, width of window timer and of each spike count
- `clk` input 1, clock, all state updates on rising edge
- `rstn` input 1, asynchronous active-low reset
- `in_valid` input 1, one integration step is presented this cycle
- `in_current` input NUM_CH*DATA_WIDTH, packed signed currents; channel i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- `threshold` input NUM_CH*DATA_WIDTH, packed signed thresholds, same packing; a value <= 0 disables firing for that channel
- `reset_mode` input 1, 0 = reset-to-zero after spike, 1 = reset-by-subtraction
- `accumulate_interval` input TIMER_WIDTH, steps per window minus one
- `clear` input 1, synchronous clear of potentials, counts and timer
- `spike` output NUM_CH, per-channel spike of the current step, registered
- `out_counts` output NUM_CH*TIMER_WIDTH, packed spike counts of the last completed window
- `out_valid` output 1, `out_counts` holds an unconsumed window
- `out_ready` input 1, consumer accepts `out_counts`
- `overflow` output 1, sticky: a window completed while `out_valid` was high and not accepted

## Operation
- Per channel, on each step (`in_valid`=1):
  - sum = potential + current, computed at DATA_WIDTH+1 bits, saturated to the signed DATA_WIDTH range.
  - fire = (threshold > 0) && (sum >= threshold).
  - If fire and mode 0: potential <= 0. If fire and mode 1: potential <= sum - threshold.
  - If no fire: potential <= sum.
- Spike count: increments on fire and saturates at 2^TIMER_WIDTH-1 (no wrap).
- Window timer: increments per step. A step is the last of its window when timer >= `accumulate_interval`; the comparison uses the live interval value.
  - Interval 0 gives one step per window.
  - Lowering the interval mid-window ends the window on the next step.
- Window end:
  - `out_counts` <= counts including this step's spike.
  - Counts <= 0, timer <= 0, `out_valid` <= 1.
  - If `out_valid` was high and `out_ready` was low in that cycle, the old data is overwritten and `overflow` <= 1.
- Handshake: transfer occurs when `out_valid` && `out_ready`; then `out_valid` <= 0, unless a window ends in the same cycle, in which case it stays 1 with the new data and no overflow is flagged.
- `clear` zeroes potentials, counts and timer, and the `spike` register. It does not touch `out_counts`, `out_valid` or `overflow`. `clear` wins over a simultaneous `in_valid`.
- `overflow` is cleared only by reset.
- `in_valid`=0: all per-channel state and the timer hold; `spike` <= 0.

## Timing
- Reset values: `spike`=0, `out_counts`=0, `out_valid`=0, `overflow`=0; potentials, counts and timer are 0.
- `spike` is valid 1 cycle after the step that fires.
- `out_valid` rises 1 cycle after the window's last step, with `out_counts` stable until the transfer or an overwrite.
- Throughput: one step per cycle, with no stalls from the output side. Back-pressure never blocks integration.
- A reset mid-window discards the partial window. No output is produced for it.

## Test plan
- Constant step input: NUM_CH=4, thresholds 10, current 4 on all channels, mode 0, interval 7, `out_ready`=1.
  - Required: spikes on steps 3, 6, 9…; after 8 steps `out_counts`=2 per channel, and `out_valid` pulses for 1 cycle.
- Reset-by-subtraction: mode 1, threshold 10, current 4, interval 9.
  - Required: potential sequence 4, 8, 2, 6, 0…; 10 steps give count 4.
- Saturation limits:
  - Current 0x7FFF with threshold 0x7FFF: potential saturates and does not wrap, and the channel fires every step.
  - TIMER_WIDTH=5, interval 31, fire every step: count = 31, not 0.
- Back-pressure: `out_ready`=0 across two window ends.
  - Required: `overflow`=1; `out_counts` = second window's values.
  - Then `out_ready`=1 for one cycle: `out_valid` drops, and `overflow` stays 1.
- Simultaneous transfer and window end with interval 0: `out_valid` stays 1 continuously, new counts appear each cycle, and `overflow` stays 0.
- `clear` and `rstn` mid-window:
  - `clear` after 3 steps: counts and timer restart, and the next window needs the full interval+1 steps.
  - `rstn` pulse mid-window: all outputs return to 0 asynchronously.
  - Non-positive threshold: the channel never fires.

Source files
------------

// File: rtl/spike_accumulator_array_if.sv
// Bundle between the PE array / controller and the integrate-and-fire stage.
// master: upstream side driving steps, configuration and the output consumer's ready.
// slave : the spike_accumulator_array itself.
// Signals: in_valid, in_current, threshold, reset_mode, accumulate_interval, clear,
//          out_ready (master -> slave); spike, out_counts, out_valid, overflow (slave -> master).
interface spike_accumulator_array_if #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned TIMER_WIDTH = 5
);
  logic                            in_valid;
  logic [NUM_CH*DATA_WIDTH-1:0]    in_current;
  logic [NUM_CH*DATA_WIDTH-1:0]    threshold;
  logic                            reset_mode;
  logic [TIMER_WIDTH-1:0]          accumulate_interval;
  logic                            clear;
  logic [NUM_CH-1:0]               spike;
  logic [NUM_CH*TIMER_WIDTH-1:0]   out_counts;
  logic                            out_valid;
  logic                            out_ready;
  logic                            overflow;

  modport master (
    output in_valid, in_current, threshold, reset_mode, accumulate_interval, clear, out_ready,
    input  spike, out_counts, out_valid, overflow
  );

  modport slave (
    input  in_valid, in_current, threshold, reset_mode, accumulate_interval, clear, out_ready,
    output spike, out_counts, out_valid, overflow
  );
endinterface

// File: rtl/spike_accumulator_array.sv
// Integrate-and-fire activation stage: per-channel membrane potential with saturating
// integration, threshold firing (reset-to-zero or reset-by-subtraction), windowed spike
// counting and a valid/ready output buffer with a sticky overwrite flag.
// Ports: clk, rstn (async active-low), bus (slave modport of spike_accumulator_array_if).
module spike_accumulator_array #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned TIMER_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rstn,
  spike_accumulator_array_if.slave  bus
);
  localparam int unsigned SUM_W = DATA_WIDTH + 1;
  localparam logic signed [DATA_WIDTH-1:0] POT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] POT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic signed [DATA_WIDTH-1:0]  pot       [NUM_CH];
  logic        [TIMER_WIDTH-1:0] cnt       [NUM_CH];
  logic        [TIMER_WIDTH-1:0] timer;
  logic        [NUM_CH-1:0]      spike_q;
  logic [NUM_CH*TIMER_WIDTH-1:0] counts_q;
  logic                          valid_q;
  logic                          ovf_q;

  logic signed [DATA_WIDTH-1:0]  pot_nxt_c [NUM_CH];
  logic        [TIMER_WIDTH-1:0] cnt_nxt_c [NUM_CH];
  logic        [NUM_CH-1:0]      fire_c;
  logic [NUM_CH*TIMER_WIDTH-1:0] cnt_pack_c;
  logic                          win_end_c;

  // Per-channel integrate, saturate, fire and count for the step being presented.
  always_comb begin
    logic signed [SUM_W-1:0]      sum_w;
    logic signed [DATA_WIDTH-1:0] sat;
    logic signed [DATA_WIDTH-1:0] cur;
    logic signed [DATA_WIDTH-1:0] thr;
    sum_w      = '0;
    sat        = '0;
    cur        = '0;
    thr        = '0;
    fire_c     = '0;
    cnt_pack_c = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pot_nxt_c[i] = pot[i];
      cnt_nxt_c[i] = cnt[i];
    end
    for (int i = 0; i < NUM_CH; i++) begin
      cur   = bus.in_current[i*DATA_WIDTH +: DATA_WIDTH];
      thr   = bus.threshold[i*DATA_WIDTH +: DATA_WIDTH];
      sum_w = {pot[i][DATA_WIDTH-1], pot[i]} + {cur[DATA_WIDTH-1], cur};
      // Top two bits disagree only when the sum left the DATA_WIDTH range.
      if (sum_w[DATA_WIDTH] != sum_w[DATA_WIDTH-1]) begin
        sat = sum_w[DATA_WIDTH] ? POT_MIN : POT_MAX;
      end else begin
        sat = sum_w[DATA_WIDTH-1:0];
      end
      fire_c[i] = (thr > 0) && (sat >= thr);
      if (fire_c[i]) begin
        pot_nxt_c[i] = bus.reset_mode ? (sat - thr) : '0;
        if (cnt[i] != '1) begin
          cnt_nxt_c[i] = TIMER_WIDTH'(cnt[i] + 1'b1);
        end
      end else begin
        pot_nxt_c[i] = sat;
      end
      cnt_pack_c[i*TIMER_WIDTH +: TIMER_WIDTH] = cnt_nxt_c[i];
    end
    // Live interval compare: lowering it mid-window ends the window on the next step.
    win_end_c = bus.in_valid && !bus.clear && (timer >= bus.accumulate_interval);
  end

  // Potentials, counts, window timer and the spike register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_CH; i++) begin
        pot[i] <= '0;
        cnt[i] <= '0;
      end
      timer   <= '0;
      spike_q <= '0;
    end else if (bus.clear) begin
      for (int i = 0; i < NUM_CH; i++) begin
        pot[i] <= '0;
        cnt[i] <= '0;
      end
      timer   <= '0;
      spike_q <= '0;
    end else if (bus.in_valid) begin
      spike_q <= fire_c;
      for (int i = 0; i < NUM_CH; i++) begin
        pot[i] <= pot_nxt_c[i];
        cnt[i] <= win_end_c ? '0 : cnt_nxt_c[i];
      end
      timer <= win_end_c ? '0 : TIMER_WIDTH'(timer + 1'b1);
    end else begin
      spike_q <= '0;
    end
  end

  // Output buffer: a window end always loads and wins over a same-cycle transfer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      counts_q <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (win_end_c) begin
      counts_q <= cnt_pack_c;
      valid_q  <= 1'b1;
      if (valid_q && !bus.out_ready) begin
        ovf_q <= 1'b1;
      end
    end else if (valid_q && bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.spike      = spike_q;
  assign bus.out_counts = counts_q;
  assign bus.out_valid  = valid_q;
  assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_spike_accumulator_array.sv
// Self-checking bench for spike_accumulator_array: integer-arithmetic neuron model
// compared every cycle, plus hand-computed directed expectations.
module tb_spike_accumulator_array;
  localparam int unsigned NCH = 4;
  localparam int unsigned DW  = 16;
  localparam int unsigned TW  = 5;
  localparam int          CMAX = (1 << TW) - 1;

  logic clk;
  logic rstn;
  int   checks;
  int   errors;

  spike_accumulator_array_if #(.NUM_CH(NCH), .DATA_WIDTH(DW), .TIMER_WIDTH(TW)) bus ();

  spike_accumulator_array #(.NUM_CH(NCH), .DATA_WIDTH(DW), .TIMER_WIDTH(TW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  int m_pot [NCH];
  int m_cnt [NCH];
  int m_out [NCH];
  int m_timer;
  logic [NCH-1:0] m_spike;
  bit m_valid;
  bit m_ovf;
  bit m_wend;
  int m_cur, m_thr, m_sum;
  logic signed [DW-1:0] m_tmp;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NCH; i++) begin
        m_pot[i] = 0; m_cnt[i] = 0; m_out[i] = 0;
      end
      m_timer = 0; m_spike = '0; m_valid = 0; m_ovf = 0;
    end else begin
      m_wend = 0;
      if (bus.clear) begin
        for (int i = 0; i < NCH; i++) begin
          m_pot[i] = 0; m_cnt[i] = 0;
        end
        m_timer = 0; m_spike = '0;
      end else if (bus.in_valid) begin
        for (int i = 0; i < NCH; i++) begin
          m_tmp = bus.in_current[i*DW +: DW]; m_cur = m_tmp;
          m_tmp = bus.threshold[i*DW +: DW];  m_thr = m_tmp;
          m_sum = m_pot[i] + m_cur;
          if (m_sum > 32767)  m_sum = 32767;
          if (m_sum < -32768) m_sum = -32768;
          m_spike[i] = (m_thr > 0) && (m_sum >= m_thr);
          if (m_spike[i]) begin
            m_pot[i] = bus.reset_mode ? m_sum - m_thr : 0;
            if (m_cnt[i] < CMAX) m_cnt[i]++;
          end else begin
            m_pot[i] = m_sum;
          end
        end
        if (m_timer >= int'(bus.accumulate_interval)) begin
          m_wend = 1;
          for (int i = 0; i < NCH; i++) begin
            m_out[i] = m_cnt[i]; m_cnt[i] = 0;
          end
          m_timer = 0;
        end else begin
          m_timer++;
        end
      end else begin
        m_spike = '0;
      end
      if (m_wend) begin
        if (m_valid && !bus.out_ready) m_ovf = 1;
        m_valid = 1;
      end else if (m_valid && bus.out_ready) begin
        m_valid = 0;
      end
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  logic [NCH*TW-1:0] exp_counts;
  always @(negedge clk) begin
    for (int i = 0; i < NCH; i++) exp_counts[i*TW +: TW] = TW'(m_out[i]);
    chk("cyc_spike",     64'(bus.spike),      64'(m_spike));
    chk("cyc_out_valid", 64'(bus.out_valid),  64'(m_valid));
    chk("cyc_overflow",  64'(bus.overflow),   64'(m_ovf));
    chk("cyc_out_counts", 64'(bus.out_counts), 64'(exp_counts));
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_ch(input int i, input int cur, input int thr);
    bus.in_current[i*DW +: DW] = DW'(cur);
    bus.threshold[i*DW +: DW]  = DW'(thr);
  endtask

  task automatic set_all(input int cur, input int thr);
    for (int i = 0; i < NCH; i++) set_ch(i, cur, thr);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("rst_spike",      64'(bus.spike),      64'd0);
    chk("rst_out_valid",  64'(bus.out_valid),  64'd0);
    chk("rst_overflow",   64'(bus.overflow),   64'd0);
    chk("rst_out_counts", 64'(bus.out_counts), 64'd0);
    bus.in_valid = 1'b0; bus.clear = 1'b0;
    @(negedge clk);
    #2 rstn = 1'b1;
  endtask

  task automatic steps(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
    end
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  int pot_seq [5];

  initial begin
    checks = 0; errors = 0;
    rstn = 1'b0;
    bus.in_valid = 1'b0; bus.clear = 1'b0; bus.reset_mode = 1'b0;
    bus.accumulate_interval = '0; bus.out_ready = 1'b1;
    bus.in_current = '0; bus.threshold = '0;

    // 1: constant input, reset-to-zero, 8-step window
    do_reset();
    set_all(4, 10); bus.reset_mode = 1'b0; bus.accumulate_interval = 5'd7; bus.out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      if (k == 4) chk("t1_spike_step3", 64'(bus.spike), 64'hF);
      if (k == 5) chk("t1_nospike_step4", 64'(bus.spike), 64'h0);
    end
    idle();
    chk("t1_valid", 64'(bus.out_valid), 64'd1);
    chk("t1_counts", 64'(bus.out_counts), 64'({5'd2, 5'd2, 5'd2, 5'd2}));
    idle();
    chk("t1_valid_pulse", 64'(bus.out_valid), 64'd0);

    // 2: reset-by-subtraction, potential 4,8,2,6,0, 10 steps -> 4 spikes
    do_reset();
    set_all(4, 10); bus.reset_mode = 1'b1; bus.accumulate_interval = 5'd9;
    pot_seq[0] = 4; pot_seq[1] = 8; pot_seq[2] = 2; pot_seq[3] = 6; pot_seq[4] = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      if (k >= 2 && k <= 6) chk("t2_model_pot", 64'(m_pot[0]), 64'(pot_seq[k-2]));
    end
    idle();
    chk("t2_counts", 64'(bus.out_counts), 64'({5'd4, 5'd4, 5'd4, 5'd4}));

    // 3: saturation, count saturation at 31, non-positive thresholds never fire
    do_reset();
    bus.reset_mode = 1'b0; bus.accumulate_interval = 5'd31;
    set_ch(0, 32'h7FFF, 32'h7FFF);
    set_ch(1, 32'h7FFF, 32'h7FFF);
    set_ch(2, 32'h7FFF, 0);
    set_ch(3, -32768, -5);
    steps(3);
    @(negedge clk);
    chk("t3_spike_every_step", 64'(bus.spike), 64'h3);
    steps(28);
    idle();
    chk("t3_counts", 64'(bus.out_counts), 64'({5'd0, 5'd0, 5'd31, 5'd31}));
    chk("t3_model_pot_hi", 64'(m_pot[2]), 64'(32767));
    chk("t3_model_pot_lo", 64'(m_pot[3]), 64'(-32768));

    // 4: back-pressure across two window ends, then a single transfer
    do_reset();
    bus.reset_mode = 1'b0; bus.out_ready = 1'b0; bus.accumulate_interval = 5'd1;
    set_ch(0, 10, 10); set_ch(1, 5, 10); set_ch(2, 0, 10); set_ch(3, 3, 10);
    steps(2);
    @(negedge clk);
    bus.accumulate_interval = 5'd3;
    bus.in_valid = 1'b1;
    steps(3);
    idle();
    chk("t4_overflow", 64'(bus.overflow), 64'd1);
    chk("t4_counts_second", 64'(bus.out_counts), 64'({5'd1, 5'd0, 5'd2, 5'd4}));
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("t4_valid_drop", 64'(bus.out_valid), 64'd0);
    chk("t4_overflow_sticky", 64'(bus.overflow), 64'd1);

    // 5: interval 0 with ready high: back-to-back windows, no overflow
    do_reset();
    bus.out_ready = 1'b1; bus.accumulate_interval = 5'd0; bus.reset_mode = 1'b0;
    set_all(0, 10);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      set_ch(0, (k % 2 == 0) ? 10 : 0, 10);
      if (k >= 2) begin
        chk("t5_valid_held", 64'(bus.out_valid), 64'd1);
        chk("t5_counts_ch0", 64'(bus.out_counts[TW-1:0]), 64'((k % 2 == 0) ? 0 : 1));
      end
    end
    idle();
    chk("t5_no_overflow", 64'(bus.overflow), 64'd0);

    // 6: clear after 3 steps restarts the window; then async reset mid-window
    do_reset();
    bus.out_ready = 1'b0; bus.accumulate_interval = 5'd3; bus.reset_mode = 1'b0;
    set_all(4, 10);
    steps(3);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    chk("t6_spike_cleared", 64'(bus.spike), 64'd0);
    steps(2);
    @(negedge clk);
    chk("t6_no_early_window", 64'(bus.out_valid), 64'd0);
    idle();
    chk("t6_window_after_full", 64'(bus.out_valid), 64'd1);
    chk("t6_counts", 64'(bus.out_counts), 64'({5'd1, 5'd1, 5'd1, 5'd1}));
    steps(3);
    do_reset();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
